// File: rtl/imm_pkg.sv
// Shared definitions for the immediate encoder: opcodes, format classes, the NOP
// substitute word and the sign-extension range check.
package imm_pkg;

  localparam logic [6:0]  OP_LD     = 7'd3;
  localparam logic [6:0]  OP_ADDI   = 7'd19;
  localparam logic [6:0]  OP_SD     = 7'd35;
  localparam logic [6:0]  OP_BRANCH = 7'd99;
  localparam logic [6:0]  OP_LUI    = 7'd55;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic [2:0] {FMT_I, FMT_S, FMT_SB, FMT_U, FMT_BAD} fmt_t;

  function automatic fmt_t fmt_of(input logic [6:0] op);
    case (op)
      OP_LD, OP_ADDI: return FMT_I;
      OP_SD:          return FMT_S;
      OP_BRANCH:      return FMT_SB;
      OP_LUI:         return FMT_U;
      default:        return FMT_BAD;
    endcase
  endfunction

  // True when v equals the sign-extension of its low n bits: everything above
  // bit n-2 must collapse to all zeros or all ones after an arithmetic shift.
  function automatic logic fits(input logic signed [63:0] v, input int unsigned n);
    logic signed [63:0] sh;
    sh = v >>> (n - 1);
    return (sh == '0) || (sh == '1);
  endfunction

endpackage

// File: rtl/imm_fifo.sv
// Two-entry synchronous FIFO. Pointers/occupancy are reset; storage is not,
// so the read port is forced to zero whenever the FIFO is empty.
module imm_fifo
  import imm_pkg::*;
#(
  parameter int DATA_W = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              not_full,
  output logic              not_empty
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              do_push;
  logic              do_pop;

  assign not_full  = (count < 2'd2);
  assign not_empty = (count != 2'd0);
  assign do_push   = push && not_full;
  assign do_pop    = pop && not_empty;
  assign pop_data  = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/imm_encoder.sv
// Encodes a register/immediate request into a 32-bit instruction word, substituting
// a NOP on range/alignment/opcode errors, and buffers results in a 2-entry FIFO.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [6:0]              in_opcode,
  input  logic [4:0]              in_rd,
  input  logic [4:0]              in_rs1,
  input  logic [4:0]              in_rs2,
  input  logic [2:0]              in_funct3,
  input  logic signed [63:0]      in_imm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic                    out_err,
  output logic [ERR_W-1:0]        err_count
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  fmt_t        fmt;
  logic        enc_err;
  logic [31:0] enc_instr;
  logic        accept;
  logic [32:0] head;

  always_comb begin
    fmt       = fmt_of(in_opcode);
    enc_err   = 1'b1;
    enc_instr = NOP;
    case (fmt)
      FMT_I: begin
        enc_err   = !fits(in_imm, 12);
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_S: begin
        enc_err   = !fits(in_imm, 12);
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      FMT_SB: begin
        enc_err   = !fits(in_imm, 13) || in_imm[0];
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
      end
      FMT_U: begin
        enc_err   = !fits(in_imm, 32) || (|in_imm[11:0]);
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
      end
      default: begin
        enc_err   = 1'b1;
        enc_instr = NOP;
      end
    endcase
    if (enc_err) enc_instr = NOP;
  end

  assign accept = in_valid && in_ready;

  imm_fifo #(.DATA_W(33)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data ({enc_err, enc_instr}),
    .pop       (out_ready),
    .pop_data  (head),
    .not_full  (in_ready),
    .not_empty (out_valid)
  );

  assign out_err   = head[32];
  assign out_instr = head[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (accept && enc_err) begin
      err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed encodings, error saturation,
// backpressure ordering, reset behaviour and a randomized queue-model run.
module tb_imm_encoder;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [6:0]         in_opcode;
  logic [4:0]         in_rd, in_rs1, in_rs2;
  logic [2:0]         in_funct3;
  logic signed [63:0] in_imm;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_instr;
  logic               out_err;
  logic [7:0]         err_count;

  int checks = 0;
  int failures = 0;

  imm_encoder #(.ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference encoder written straight from the format and range rules.
  function automatic void model(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                input logic [2:0] f3, input longint imm,
                                output logic err, output logic [31:0] instr);
    logic [63:0] u;
    u = imm;
    err = 1'b0;
    instr = 32'h0;
    if (op == 7'd3 || op == 7'd19) begin
      if (imm < -2048 || imm > 2047) err = 1'b1;
      else instr = {u[11:0], rs1, f3, rd, op};
    end else if (op == 7'd35) begin
      if (imm < -2048 || imm > 2047) err = 1'b1;
      else instr = {u[11:5], rs2, rs1, f3, u[4:0], op};
    end else if (op == 7'd99) begin
      if (imm < -4096 || imm > 4094 || (imm % 2) != 0) err = 1'b1;
      else instr = {u[12], u[10:5], rs2, rs1, f3, u[4:1], u[11], op};
    end else if (op == 7'd55) begin
      if (imm < -longint'(32'h8000_0000) || imm > longint'(32'h7FFF_FFFF) || (imm % 4096) != 0)
        err = 1'b1;
      else instr = {u[31:12], rd, op};
    end else begin
      err = 1'b1;
    end
    if (err) instr = 32'h0000_0013;
  endfunction

  task automatic put(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                     input logic [2:0] f3, input longint imm);
    @(negedge clk);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain_one();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL rst_out_instr got=%h exp=00000000", out_instr); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL rst_out_err got=%b exp=0", out_err); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_directed();
    put(7'd19, 5'd5, 5'd0, 5'd0, 3'd0, -1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
    checks++; if (out_instr !== 32'hFFF00293) begin failures++; $display("FAIL addi_instr got=%h exp=FFF00293", out_instr); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL addi_err got=%b exp=0", out_err); end
    drain_one();
    put(7'd35, 5'd0, 5'd2, 5'd6, 3'd3, 16);
    checks++; if (out_instr !== 32'h00613823) begin failures++; $display("FAIL sd_instr got=%h exp=00613823", out_instr); end
    drain_one();
    put(7'd99, 5'd0, 5'd1, 5'd2, 3'd0, 8);
    checks++; if (out_instr !== 32'h00208463) begin failures++; $display("FAIL beq_instr got=%h exp=00208463", out_instr); end
    drain_one();
    put(7'd55, 5'd1, 5'd0, 5'd0, 3'd0, 64'h12345000);
    checks++; if (out_instr !== 32'h123450B7 || out_err !== 1'b0) begin failures++; $display("FAIL lui_instr got=%h/%b exp=123450B7/0", out_instr, out_err); end
    drain_one();
    put(7'd55, 5'd1, 5'd0, 5'd0, 3'd0, 64'h12345001);
    checks++; if (out_instr !== 32'h00000013 || out_err !== 1'b1) begin failures++; $display("FAIL lui_misalign got=%h/%b exp=00000013/1", out_instr, out_err); end
    drain_one();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL directed_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_errors();
    pulse_reset();
    put(7'd19, 5'd3, 5'd4, 5'd0, 3'd0, 2048);
    checks++; if (out_instr !== 32'h13 || out_err !== 1'b1) begin failures++; $display("FAIL err_addi got=%h/%b exp=00000013/1", out_instr, out_err); end
    drain_one();
    put(7'd99, 5'd0, 5'd1, 5'd2, 3'd0, 7);
    checks++; if (out_instr !== 32'h13 || out_err !== 1'b1) begin failures++; $display("FAIL err_beq got=%h/%b exp=00000013/1", out_instr, out_err); end
    drain_one();
    put(7'd51, 5'd1, 5'd1, 5'd1, 3'd0, 0);
    checks++; if (out_instr !== 32'h13 || out_err !== 1'b1) begin failures++; $display("FAIL err_op51 got=%h/%b exp=00000013/1", out_instr, out_err); end
    drain_one();
    checks++; if (err_count !== 8'd3) begin failures++; $display("FAIL err_count3 got=%0d exp=3", err_count); end
    @(negedge clk);
    in_opcode = 7'd51; in_valid = 1'b1; out_ready = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL err_sat got=%0d exp=255", err_count); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w [3];
    int got;
    logic acc;
    exp_w[0] = 32'hFFF00293; exp_w[1] = 32'h00613823; exp_w[2] = 32'h00208463;
    pulse_reset();
    put(7'd19, 5'd5, 5'd0, 5'd0, 3'd0, -1);
    put(7'd35, 5'd0, 5'd2, 5'd6, 3'd3, 16);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", in_ready); end
    @(negedge clk);
    in_opcode = 7'd99; in_rd = 5'd0; in_rs1 = 5'd1; in_rs2 = 5'd2; in_funct3 = 3'd0; in_imm = 8;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0 || out_instr !== exp_w[0]) begin failures++; $display("FAIL bp_hold got=%b/%h exp=0/%h", in_ready, out_instr, exp_w[0]); end
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        checks++; if (out_instr !== exp_w[got]) begin failures++; $display("FAIL bp_order%0d got=%h exp=%h", got, out_instr, exp_w[got]); end
        got++;
      end
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    checks++; if (got !== 3 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_count got=%0d/%b exp=3/0", got, out_valid); end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    put(7'd51, 5'd0, 5'd0, 5'd0, 3'd0, 0);
    put(7'd19, 5'd5, 5'd0, 5'd0, 3'd0, -1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_flags got=%b/%b exp=0/1", out_valid, in_ready); end
    checks++; if (err_count !== 8'd0 || out_instr !== 32'h0 || out_err !== 1'b0) begin failures++; $display("FAIL mid_rst_state got=%0d/%h/%b exp=0/00000000/0", err_count, out_instr, out_err); end
    @(negedge clk);
    rst_n = 1'b1;
    put(7'd35, 5'd0, 5'd2, 5'd6, 3'd3, 16);
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00613823) begin failures++; $display("FAIL mid_after got=%b/%h exp=1/00613823", out_valid, out_instr); end
    drain_one();
  endtask

  task automatic test_random();
    logic [32:0] q[$];
    int exp_cnt;
    logic e;
    logic [31:0] w;
    logic acc, pop;
    logic [6:0] ops [7];
    longint edges [10];
    logic [31:0] r;
    ops = '{7'd3, 7'd19, 7'd35, 7'd99, 7'd55, 7'd51, 7'd0};
    edges = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098, 0};
    pulse_reset();
    exp_cnt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 5);
      in_opcode = ops[$urandom_range(0, 6)];
      if (in_opcode == 7'd0) in_opcode = 7'($urandom);
      in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom); in_funct3 = 3'($urandom);
      r = $urandom;
      case ($urandom_range(0, 3))
        0: in_imm = longint'($urandom_range(0, 10000)) - 5000;
        1: in_imm = {{32{r[31]}}, r[31:12], 12'h000};
        2: in_imm = {$urandom, $urandom};
        default: in_imm = edges[$urandom_range(0, 9)];
      endcase
      #1;
      checks++; if (in_ready !== (q.size() < 2)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, q.size() < 2); end
      checks++; if (out_valid !== (q.size() > 0)) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        checks++; if ({out_err, out_instr} !== q[0]) begin failures++; $display("FAIL rnd_word cyc=%0d got=%h exp=%h", cyc, {out_err, out_instr}, q[0]); end
      end
      checks++; if (err_count !== 8'(exp_cnt)) begin failures++; $display("FAIL rnd_err_count cyc=%0d got=%0d exp=%0d", cyc, err_count, exp_cnt); end
      model(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, e, w);
      acc = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() > 0);
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back({e, w});
        if (e && exp_cnt < 255) exp_cnt++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
